bcd_xs3_sequencer: RTL and testbench

BCD_XS3_SEQUENCER -- requirements
Module: bcd_xs3_sequencer

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_digit_xs3.sv | 26 ++
 rtl/bcd_xs3_sequencer.sv | 110 +++++++++++
 tb/tb_bcd_xs3_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module : bcd_pkg
// Brief  : Shared encodings and constants for the BCD to Excess-3 sequencer.
// Rev    : 1.0
// ============================================================================
package bcd_pkg;

    localparam int          C_DIG_W      = 4;
    localparam logic [3:0]  C_XS3_OFFSET = 4'd3;
    localparam logic [3:0]  C_BAD_DIGIT  = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_xs3.sv
`default_nettype none
// ============================================================================
// Module : bcd_digit_xs3
// Brief  : Combinational single-digit Excess-3 converter with invalid flag.
//          The flag is only live when BCD_XS3_CHECK_EN is defined.
// Rev    : 1.0
// ============================================================================
module bcd_digit_xs3
    import bcd_pkg::*;
(
    input  logic [C_DIG_W-1:0] i_digit,
    output logic [C_DIG_W-1:0] o_xs3,
    output logic               o_invalid
);

    // Wraps modulo 16 on purpose; digits never carry into each other.
    assign o_xs3 = i_digit + C_XS3_OFFSET;

`ifdef BCD_XS3_CHECK_EN
    assign o_invalid = (i_digit > 4'd9);
`else
    assign o_invalid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/bcd_xs3_sequencer.sv
`default_nettype none
// ============================================================================
// Module : bcd_xs3_sequencer
// Brief  : Converts a packed BCD word to Excess-3, one digit per cycle, through
//          one shared digit converter. Optional macro: BCD_XS3_CHECK_EN.
// Rev    : 1.0
// ============================================================================
module bcd_xs3_sequencer
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [C_DIG_W*NDIG-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [C_DIG_W*NDIG-1:0] out_data,
    output logic                    out_err,
    output logic                    busy
);

    localparam int                W          = C_DIG_W * NDIG;
    localparam int                IDX_W      = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(NDIG - 1);
    localparam logic [IDX_W-1:0]  C_IDX_ONE  = IDX_W'(1);

    state_e             state_q, state_d;
    logic [W-1:0]       word_q, word_d;
    logic [W-1:0]       result_q, result_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [C_DIG_W-1:0] w_digit;
    logic [C_DIG_W-1:0] w_xs3;
    logic               w_invalid;
    logic [C_DIG_W-1:0] w_res_digit;

    // The latched word shifts right each CONV cycle, so digit idx sits at the bottom.
    assign w_digit = word_q[C_DIG_W-1:0];

    bcd_digit_xs3 u_digit (
        .i_digit   (w_digit),
        .o_xs3     (w_xs3),
        .o_invalid (w_invalid)
    );

    assign w_res_digit = w_invalid ? C_BAD_DIGIT : w_xs3;

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        result_d = result_q;
        err_d    = err_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d   = in_data;
                    result_d = '0;
                    err_d    = 1'b0;
                    idx_d    = '0;
                    state_d  = CONV;
                end
            end
            CONV: begin
                result_d[C_DIG_W*int'(idx_q) +: C_DIG_W] = w_res_digit;
                err_d  = err_q | w_invalid;
                word_d = word_q >> C_DIG_W;
                idx_d  = idx_q + C_IDX_ONE;
                if (idx_q == C_LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            word_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            result_q <= result_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CONV) || (state_q == DONE);
    assign out_data  = result_q;
    assign out_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_xs3_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_bcd_xs3_sequencer
// Brief  : Self-checking bench for bcd_xs3_sequencer (NDIG = 4).
// Rev    : 1.0
// ============================================================================
module tb_bcd_xs3_sequencer;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_err;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_xs3_sequencer #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy)
    );

    // Reference: each BCD digit independently becomes (d+3) mod 16, or F when checked and >9.
    function automatic void xs3_model(input logic [W-1:0] w, output logic [W-1:0] r, output logic e);
        r = '0;
        e = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            int d;
            bit bad;
            d   = int'((w >> (4 * i)) & 16'hF);
            bad = 1'b0;
`ifdef BCD_XS3_CHECK_EN
            bad = (d > 9);
`endif
            if (bad) begin
                r[4*i +: 4] = 4'hF;
                e = 1'b1;
            end else begin
                r[4*i +: 4] = 4'((d + 3) % 16);
            end
        end
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < NDIG; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_word(input logic [W-1:0] w, input logic [W-1:0] exp_d, input logic exp_e, input string name);
        int cyc;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_ready: got %b expected 1", name, in_ready);
        end
        in_valid  = 1'b1;
        in_data   = w;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = W'($urandom);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s conv_flags: got busy=%b in_ready=%b expected busy=1 in_ready=0", name, busy, in_ready);
        end
        wait_valid(cyc);
        checks++;
        if (cyc != NDIG) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc, NDIG);
        end
        checks++;
        if (out_data !== exp_d || out_err !== exp_e) begin
            errors++;
            $display("FAIL %s result: got data=%h err=%b expected data=%h err=%b", name, out_data, out_err, exp_d, exp_e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s handoff: got in_ready=%b out_valid=%b busy=%b expected 1 0 0", name, in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b data=%h err=%b busy=%b expected 1 0 0000 0 0",
                     in_ready, out_valid, out_data, out_err, busy);
        end
    endtask

    task automatic test_known();
        run_word(16'h1234, 16'h4567, 1'b0, "w1234");
        run_word(16'h9900, 16'hCC33, 1'b0, "w9900");
        run_word(16'h0000, 16'h3333, 1'b0, "w0000");
        run_word(16'h9999, 16'hCCCC, 1'b0, "w9999");
`ifdef BCD_XS3_CHECK_EN
        run_word(16'h0A05, 16'h3F38, 1'b1, "w0A05");
`else
        run_word(16'h0A05, 16'h3D38, 1'b0, "w0A05");
`endif
    endtask

    task automatic test_random_words();
        for (int n = 0; n < 12; n++) begin
            logic [W-1:0] w, r;
            logic e;
            w = W'($urandom);
            xs3_model(w, r, e);
            run_word(w, r, e, "random");
        end
    endtask

    task automatic test_out_ready_idle();
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_out_ready: got rdy=%b vld=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [W-1:0] w, r;
        logic e;
        int cyc;
        w = rand_bcd();
        xs3_model(w, r, e);
        @(negedge clk);
        in_valid = 1'b1; in_data = w; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(cyc);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            in_data  = W'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== r || out_err !== e || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: got vld=%b data=%h err=%b rdy=%b expected 1 %h %b 0",
                         out_valid, out_data, out_err, in_ready, r, e);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h5678;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got rdy=%b vld=%b data=%h err=%b busy=%b expected 1 0 0000 0 0",
                     in_ready, out_valid, out_data, out_err, busy);
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        run_word(16'h0001, 16'h3334, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_q[$];
        int cyc, got, last_acc;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; in_data = rand_bcd();
        cyc = 0; got = 0; last_acc = -1;
        while (got < 100 && cyc < 100 * (NDIG + 2) + 100) begin
            if (in_ready) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != NDIG + 2) begin
                        errors++;
                        $display("FAIL b2b_gap: got %0d expected %0d", cyc - last_acc, NDIG + 2);
                    end
                end
                exp_q.push_back(in_data);
                last_acc = cyc;
            end else begin
                in_data = rand_bcd();
            end
            if (out_valid) begin
                logic [W-1:0] w, r;
                logic e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: got data=%h expected no output", out_data);
                end else begin
                    w = exp_q.pop_front();
                    xs3_model(w, r, e);
                    if (out_data !== r || out_err !== e) begin
                        errors++;
                        $display("FAIL b2b_data: got %h err=%b expected %h err=%b", out_data, out_err, r, e);
                    end
                end
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 100) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 100", got);
        end
        repeat (NDIG + 3) @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_known();
        test_random_words();
        test_out_ready_idle();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
